// File: rtl/rgb_gray_pipe.sv
// RGB-to-grey pixel pipeline. Each pixel is tagged with its frame column and line.
// Define RGB_GRAY_PIPE_THRESH_EN to add a binary threshold on the output (iTHRESH port).
module rgb_gray_pipe #(
    parameter int unsigned DW      = 12,
    parameter int unsigned FRAME_W = 640,
    parameter int unsigned FRAME_H = 480,
    localparam int unsigned XW     = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
    localparam int unsigned YW     = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iDVAL,
    input  logic [DW-1:0] iRed,
    input  logic [DW-1:0] iGreen,
    input  logic [DW-1:0] iBlue,
    input  logic [1:0]    iMODE,
    input  logic          iFRAME_CLR,
`ifdef RGB_GRAY_PIPE_THRESH_EN
    input  logic [DW-1:0] iTHRESH,
`endif
    output logic [DW-1:0] oDATA,
    output logic          oDVAL,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic          oFRAME_END
);

    localparam int unsigned SW = DW + 8;

    // position counters
    logic [XW-1:0] x_q, x_d, x_tag;
    logic [YW-1:0] y_q, y_d, y_tag;
    logic          end_tag;

    // stage 0: registered input pixel
    logic          v0_q;
    logic [1:0]    mode0_q;
    logic [DW-1:0] r0_q, g0_q, b0_q;
    logic [XW-1:0] x0_q;
    logic [YW-1:0] y0_q;
    logic          end0_q;

    // stage 1: per-mode accumulation
    logic          v1_q;
    logic [1:0]    mode1_q;
    logic [SW-1:0] acc1_q, acc_d;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y1_q;
    logic          end1_q;

    // stage 2: grey value
    logic          v2_q;
    logic [DW-1:0] grey2_q, grey_d;
    logic [XW-1:0] x2_q;
    logic [YW-1:0] y2_q;
    logic          end2_q;

    // stage 3: output registers
    logic [DW-1:0] data_q, data_d, out_val;
    logic          dval_q;
    logic [XW-1:0] xo_q, xo_d;
    logic [YW-1:0] yo_q, yo_d;
    logic          fend_q;

    logic [DW-1:0] max_rgb;

    // A clear in the same cycle as a pixel retags that pixel as the frame origin.
    always_comb begin : pos_next
        x_tag   = iFRAME_CLR ? '0 : x_q;
        y_tag   = iFRAME_CLR ? '0 : y_q;
        end_tag = (x_tag == XW'(FRAME_W - 1)) && (y_tag == YW'(FRAME_H - 1));
        x_d     = x_q;
        y_d     = y_q;
        if (iDVAL) begin
            if (x_tag == XW'(FRAME_W - 1)) begin
                x_d = '0;
                y_d = (y_tag == YW'(FRAME_H - 1)) ? '0 : y_tag + YW'(1);
            end else begin
                x_d = x_tag + XW'(1);
                y_d = y_tag;
            end
        end else if (iFRAME_CLR) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_comb begin : stage1_next
        max_rgb = r0_q;
        if (g0_q > max_rgb) max_rgb = g0_q;
        if (b0_q > max_rgb) max_rgb = b0_q;
        acc_d = '0;
        case (mode0_q)
            2'b00:   acc_d = SW'(r0_q) + SW'(g0_q) + SW'(b0_q);
            2'b01:   acc_d = SW'(77) * SW'(r0_q) + SW'(150) * SW'(g0_q) + SW'(29) * SW'(b0_q);
            2'b10:   acc_d = SW'(g0_q);
            default: acc_d = SW'(max_rgb);
        endcase
    end

    always_comb begin : stage2_next
        grey_d = '0;
        case (mode1_q)
            2'b00:   grey_d = DW'(acc1_q / SW'(3));
            2'b01:   grey_d = DW'(acc1_q >> 8);
            default: grey_d = DW'(acc1_q);
        endcase
    end

    // Data and position hold their last values across invalid cycles.
    always_comb begin : stage3_next
`ifdef RGB_GRAY_PIPE_THRESH_EN
        out_val = (grey2_q >= iTHRESH) ? {DW{1'b1}} : '0;
`else
        out_val = grey2_q;
`endif
        data_d = v2_q ? out_val : data_q;
        xo_d   = v2_q ? x2_q : xo_q;
        yo_d   = v2_q ? y2_q : yo_q;
    end

    always_ff @(posedge iCLK or negedge iRST) begin : regs
        if (!iRST) begin
            x_q     <= '0;
            y_q     <= '0;
            v0_q    <= 1'b0;
            mode0_q <= '0;
            r0_q    <= '0;
            g0_q    <= '0;
            b0_q    <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            end0_q  <= 1'b0;
            v1_q    <= 1'b0;
            mode1_q <= '0;
            acc1_q  <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            end1_q  <= 1'b0;
            v2_q    <= 1'b0;
            grey2_q <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            end2_q  <= 1'b0;
            data_q  <= '0;
            dval_q  <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
            fend_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            v0_q    <= iDVAL;
            mode0_q <= iMODE;
            r0_q    <= iRed;
            g0_q    <= iGreen;
            b0_q    <= iBlue;
            x0_q    <= x_tag;
            y0_q    <= y_tag;
            end0_q  <= iDVAL & end_tag;
            v1_q    <= v0_q;
            mode1_q <= mode0_q;
            acc1_q  <= acc_d;
            x1_q    <= x0_q;
            y1_q    <= y0_q;
            end1_q  <= end0_q;
            v2_q    <= v1_q;
            grey2_q <= grey_d;
            x2_q    <= x1_q;
            y2_q    <= y1_q;
            end2_q  <= end1_q;
            data_q  <= data_d;
            dval_q  <= v2_q;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            fend_q  <= v2_q & end2_q;
        end
    end

    assign oDATA      = data_q;
    assign oDVAL      = dval_q;
    assign oX         = xo_q;
    assign oY         = yo_q;
    assign oFRAME_END = fend_q;

endmodule

// File: tb/tb_rgb_gray_pipe.sv
// Self-checking bench for rgb_gray_pipe (DW=12, 4x2 frame) against a per-pixel reference model.
module tb_rgb_gray_pipe;

    localparam int DW = 12;
    localparam int FW = 4;
    localparam int FH = 2;
    localparam int N  = 64;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iDVAL = 1'b0;
    logic [DW-1:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic [1:0]    iMODE = '0;
    logic          iFRAME_CLR = 1'b0;
`ifdef RGB_GRAY_PIPE_THRESH_EN
    logic [DW-1:0] iTHRESH = 12'd600;
`endif
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic [1:0]    oX;
    logic          oY;
    logic          oFRAME_END;

    rgb_gray_pipe #(.DW(DW), .FRAME_W(FW), .FRAME_H(FH)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iMODE(iMODE), .iFRAME_CLR(iFRAME_CLR),
`ifdef RGB_GRAY_PIPE_THRESH_EN
        .iTHRESH(iTHRESH),
`endif
        .oDATA(oDATA), .oDVAL(oDVAL), .oX(oX), .oY(oY), .oFRAME_END(oFRAME_END)
    );

    always #5 iCLK = ~iCLK;

    int edge_cnt = 0;
    always @(posedge iCLK) edge_cnt <= edge_cnt + 1;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // expected output per output-edge slot
    int exp_v[N], exp_d[N], exp_x[N], exp_y[N], exp_f[N];
    int lit_d[N], lit_x[N], lit_y[N], lit_f[N];
    int held_d, held_x, held_y;
    int px, py;
    bit chk_on = 1'b0;

    function automatic int to_out(input int grey);
`ifdef RGB_GRAY_PIPE_THRESH_EN
        return (grey >= 600) ? 4095 : 0;
`else
        return grey;
`endif
    endfunction

    function automatic int grey_of(input int r, input int g, input int b, input int m);
        int mx;
        mx = (r > g) ? r : g;
        mx = (mx > b) ? mx : b;
        case (m)
            0:       return (r + g + b) / 3;
            1:       return (77 * r + 150 * g + 29 * b) / 256;
            2:       return g;
            default: return mx;
        endcase
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < N; k++) begin
            exp_v[k] = 0; exp_d[k] = 0; exp_x[k] = 0; exp_y[k] = 0; exp_f[k] = 0;
            lit_d[k] = -1; lit_x[k] = -1; lit_y[k] = -1; lit_f[k] = -1;
        end
        held_d = 0; held_x = 0; held_y = 0;
        px = 0; py = 0;
    endfunction

    task automatic drive(input bit v, input int r, input int g, input int b, input int m,
                         input bit clr, input int ld = -1, input int lx = -1,
                         input int ly = -1, input int lf = -1);
        int i;
        @(negedge iCLK);
        iDVAL = v; iRed = 12'(r); iGreen = 12'(g); iBlue = 12'(b);
        iMODE = 2'(m); iFRAME_CLR = clr;
        i = (edge_cnt + 3) % N;
        if (clr) begin px = 0; py = 0; end
        exp_v[i] = v;
        lit_d[i] = ld; lit_x[i] = lx; lit_y[i] = ly; lit_f[i] = lf;
        if (v) begin
            exp_d[i] = to_out(grey_of(r, g, b, m));
            exp_x[i] = px;
            exp_y[i] = py;
            exp_f[i] = (px == FW - 1 && py == FH - 1) ? 1 : 0;
            px++;
            if (px == FW) begin
                px = 0;
                py = (py == FH - 1) ? 0 : py + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, int'(oDATA), 0);
        chk({tag, "_dval"}, int'(oDVAL), 0);
        chk({tag, "_x"}, int'(oX), 0);
        chk({tag, "_y"}, int'(oY), 0);
        chk({tag, "_fend"}, int'(oFRAME_END), 0);
    endtask

    // compare DUT outputs with the model on every cycle
    always @(negedge iCLK) begin
        int i;
        if (chk_on && edge_cnt > 0) begin
            i = (edge_cnt - 1) % N;
            chk("dval", int'(oDVAL), exp_v[i]);
            if (exp_v[i] != 0) begin
                held_d = exp_d[i]; held_x = exp_x[i]; held_y = exp_y[i];
            end
            chk("data", int'(oDATA), held_d);
            chk("x", int'(oX), held_x);
            chk("y", int'(oY), held_y);
            chk("fend", int'(oFRAME_END), (exp_v[i] != 0) ? exp_f[i] : 0);
            if (lit_d[i] >= 0) chk("lit_data", int'(oDATA), lit_d[i]);
            if (lit_x[i] >= 0) chk("lit_x", int'(oX), lit_x[i]);
            if (lit_y[i] >= 0) chk("lit_y", int'(oY), lit_y[i]);
            if (lit_f[i] >= 0) chk("lit_fend", int'(oFRAME_END), lit_f[i]);
            exp_v[i] = 0;
            lit_d[i] = -1; lit_x[i] = -1; lit_y[i] = -1; lit_f[i] = -1;
        end
    end

    initial begin
        clear_model();
        #3;
        check_zero("reset");
        #9 iRST = 1'b1;
        chk_on = 1'b1;

        // one pixel in each mode, mode switching every pixel
        drive(1'b1, 300, 600, 900, 0, 1'b0, to_out(600), 0, 0, 0);
        drive(1'b1, 300, 600, 900, 1, 1'b0, to_out(543), 1, 0, 0);
        drive(1'b1, 300, 600, 900, 2, 1'b0, to_out(600), 2, 0, 0);
        drive(1'b1, 300, 600, 900, 3, 1'b0, to_out(900), 3, 0, 0);
        idle(4);

        // full-scale and zero inputs
        drive(1'b1, 4095, 4095, 4095, 0, 1'b0, to_out(4095));
        drive(1'b1, 4095, 4095, 4095, 1, 1'b0, to_out(4095));
        drive(1'b1, 0, 0, 0, 0, 1'b0, to_out(0));
        drive(1'b1, 0, 0, 0, 1, 1'b0, to_out(0), 3, 1, 1);
        idle(2);

        // two back-to-back frames from a cleared origin
        drive(1'b0, 0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 16; k++)
            drive(1'b1, (k * 257) % 4096, (k * 131 + 50) % 4096, (k * 613) % 4096, k % 4,
                  1'b0, -1, k % 4, (k / 4) % 2, (k % 8 == 7) ? 1 : 0);
        idle(4);

        // alternating valid / invalid
        for (int k = 0; k < 6; k++)
            drive(k % 2 == 0, 1000 + k, 2000, 3000 - k, k % 4, 1'b0);
        idle(4);

        // threshold boundary (grey value equals input in mode 00)
        drive(1'b0, 0, 0, 0, 0, 1'b1);
        drive(1'b1, 599, 599, 599, 0, 1'b0, to_out(599));
        drive(1'b1, 600, 600, 600, 0, 1'b0, to_out(600));
        idle(4);

        // frame clear coincident with a pixel at x=2
        drive(1'b0, 0, 0, 0, 0, 1'b1);
        drive(1'b1, 10, 20, 30, 0, 1'b0, -1, 0, 0);
        drive(1'b1, 40, 50, 60, 0, 1'b0, -1, 1, 0);
        drive(1'b1, 70, 80, 90, 3, 1'b1, to_out(90), 0, 0);
        drive(1'b1, 11, 22, 33, 2, 1'b0, to_out(22), 1, 0);
        drive(1'b1, 500, 600, 700, 1, 1'b0);
        drive(1'b1, 800, 900, 1000, 0, 1'b0);

        // asynchronous reset with pixels in flight
        @(negedge iCLK);
        iDVAL = 1'b0; iFRAME_CLR = 1'b0;
        #2 iRST = 1'b0;
        #1 check_zero("midreset");
        clear_model();
        @(negedge iCLK);
        #2 iRST = 1'b1;
        drive(1'b1, 1200, 300, 2400, 3, 1'b0, to_out(2400), 0, 0, 0);
        drive(1'b1, 3, 6, 9, 0, 1'b0, to_out(6), 1, 0, 0);
        idle(6);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/rgb_gray_pipe.md
RGB_GRAY_PIPE -- requirements
Module: rgb_gray_pipe

Interface
REQ-001 Parameter DW, 12, width of each colour component and of oDATA.
REQ-002 Parameter FRAME_W, 640, active pixels per line.
REQ-003 Parameter FRAME_H, 480, active lines per frame.
REQ-004 iCLK  input  1  clock; all logic SHALL be rising-edge.
REQ-005 iRST  input  1  reset, asynchronous, active-low.
REQ-006 iDVAL  input  1  input pixel valid.
REQ-007 iRed, iGreen, iBlue  input  DW each  colour components.
REQ-008 iMODE  input  2  conversion mode, sampled with each pixel.
REQ-009 iFRAME_CLR  input  1  synchronous clear of position counters.
REQ-010 oDATA  output  DW  grey (or thresholded) pixel.
REQ-011 oDVAL  output  1  output pixel valid.
REQ-012 oX  output  clog2(FRAME_W)  column of the output pixel.
REQ-013 oY  output  clog2(FRAME_H)  line of the output pixel.
REQ-014 oFRAME_END  output  1  high with the last pixel of a frame.

Function
REQ-015 Fixed 3-cycle pipeline: a pixel with iDVAL high at edge N SHALL appear on oDATA/oDVAL/oX/oY after edge N+3; no stalls, one pixel per clock.
REQ-016 iDVAL low SHALL propagate as oDVAL low after 3 cycles; oDATA/oX/oY SHALL hold their last values while oDVAL is low.
REQ-017 iMODE=00: oDATA = floor((R+G+B)/3), exact, sum held in DW+2 bits.
REQ-018 iMODE=01: oDATA = floor((77R+150G+29B)/256), intermediates DW+8 bits, no overflow.
REQ-019 iMODE=10: oDATA = G unchanged.
REQ-020 iMODE=11: oDATA = max(R,G,B).
REQ-021 iMODE SHALL be registered with its pixel; a mode change between pixels SHALL affect only later pixels.
REQ-022 Position counter SHALL advance only on accepted pixels (iDVAL high); x counts 0..FRAME_W-1, then wraps to 0 and y increments.
REQ-023 At x=FRAME_W-1, y=FRAME_H-1, both counters SHALL wrap to 0 and oFRAME_END SHALL be high for that pixel's output cycle only.
REQ-024 iFRAME_CLR high SHALL reset x,y to 0 at the next edge; with iDVAL high in the same cycle, that pixel SHALL be tagged x=0,y=0 and the next one x=1.
REQ-025 iFRAME_CLR SHALL NOT flush pixels already in the pipeline.

Reset
REQ-026 iRST low SHALL asynchronously clear oDATA, oDVAL, oX, oY, oFRAME_END, all pipeline registers and counters to 0.
REQ-027 Reset asserted mid-frame SHALL discard in-flight pixels; the first pixel accepted after release SHALL be tagged x=0,y=0 and emerge 3 cycles later.

Configuration
REQ-028 Macro RGB_GRAY_PIPE_THRESH_EN defined: add port iTHRESH input DW; in stage 3, oDATA SHALL be all-ones if grey >= iTHRESH, else 0; latency unchanged; iTHRESH sampled in stage 3.
REQ-029 Macro not defined: no iTHRESH port; oDATA SHALL be the grey value per REQ-017..020.

Verification (DW=12, FRAME_W=4, FRAME_H=2 unless stated)
REQ-030 R=300,G=600,B=900, iDVAL=1 at edge 0 for modes 00/01/10/11 -> oDATA 600/543/600/900 at edge 3, oDVAL=1.
REQ-031 R=G=B=4095 in modes 00 and 01 -> oDATA=4095 both, no overflow; R=G=B=0 -> 0.
REQ-032 8 consecutive valid pixels, then 8 more -> oX 0,1,2,3,0,1,2,3, oY 0,0,0,0,1,1,1,1; oFRAME_END high only on 8th and 16th outputs.
REQ-033 Alternating iDVAL 1/0 for 6 cycles -> oDVAL mirrors it delayed 3 cycles; counters advance only on valid pixels.
REQ-034 iFRAME_CLR with iDVAL at pixel x=2 -> that pixel tagged (0,0), next (1,0); iRST pulse mid-frame -> all outputs 0 immediately, next pixel tagged (0,0).
REQ-035 With RGB_GRAY_PIPE_THRESH_EN, iTHRESH=600, mode 00 grey values 599/600 -> oDATA 0/4095.
